// File: rtl/cpu_pkg.sv
// Shared CPU definitions: phase encodings, NOP instruction and fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [3:0]  PH_FETCH = 4'b0001;
    localparam logic [3:0]  PH_WB    = 4'b1000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and imem.
// Latency: n/a (wires only).
// Backpressure: imem_req is a level held until the one-cycle imem_ack pulse.
// Ports: imem_req/imem_addr (fetch side -> memory), imem_rdata/imem_ack (memory -> fetch side).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select: branch/jump target when ife is set, else sequential increment.
// Latency: combinational.
// Backpressure: none.
// Ports: ife/addr_o from the alu, pc current PC, pc_next selected result.
module pc_next #(
    parameter logic [31:0] PC_STEP = 32'd1
) (
    input  logic        ife,
    input  logic [31:0] addr_o,
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);
    // Plain 32-bit add, so 32'hFFFF_FFFF + 1 wraps to zero naturally.
    assign pc_next = ife ? addr_o : (pc + PC_STEP);
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: fetches at pc_o on the fetch phase, forms next PC on write-back.
// Latency: imem_req 1 cycle after t[0] edge; ir_o valid 1 cycle after the ack edge (min 2-cycle fetch).
// Backpressure: stall_o is high for the whole outstanding request so the phase generator holds t.
// Ports: clk, rst (sync active-low), t phase, ife/addr_o from alu, ir_o/pc_o/ir_valid to alu,
//        stall_o to phase generator, imem (fetch_unit_if master), fetch_err timeout flag.
// Optional: define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT cycles with a NOP and sticky fetch_err.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         t,
    input  logic               ife,
    input  logic [31:0]        addr_o,
    output logic [31:0]        ir_o,
    output logic [31:0]        pc_o,
    output logic               ir_valid,
    output logic               stall_o,
    fetch_unit_if.master       imem,
    output logic               fetch_err
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic         r_ir_valid;
    logic         r_req;
    logic [31:0]  r_addr;
    logic [31:0]  w_pc_next;
    logic         w_ack;
    logic         w_tmo;

    pc_next #(.PC_STEP(PC_STEP)) u_pc_next (
        .ife     (ife),
        .addr_o  (addr_o),
        .pc      (r_pc),
        .pc_next (w_pc_next)
    );

    // Acks outside REQ (stale or spurious) are dropped here.
    assign w_ack = (r_state == ST_REQ) && imem.imem_ack;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic          r_err;

    // Ack on the final allowed cycle still wins over the timeout.
    assign w_tmo = (r_state == ST_REQ) && !imem.imem_ack && (r_tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state != ST_REQ)
                r_tmo_cnt <= '0;
            else if (!w_tmo)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_tmo)
                r_err <= 1'b1;
        end
    end

    assign fetch_err = r_err;
`else
    assign w_tmo     = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (t == PH_FETCH)   w_state_next = ST_REQ;
            ST_REQ:  if (w_ack || w_tmo)  w_state_next = ST_DONE;
            ST_DONE: if (t == PH_WB)      w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (t == PH_FETCH) begin
                        r_req      <= 1'b1;
                        r_addr     <= r_pc;
                        r_ir_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        r_ir       <= imem.imem_rdata;
                        r_ir_valid <= 1'b1;
                        r_req      <= 1'b0;
                    end else if (w_tmo) begin
                        r_ir       <= NOP_INSN;
                        r_ir_valid <= 1'b1;
                        r_req      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (t == PH_WB) begin
                        r_pc       <= w_pc_next;
                        r_ir_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir_o           = r_ir;
    assign pc_o           = r_pc;
    assign ir_valid       = r_ir_valid;
    assign stall_o        = (r_state == ST_REQ);
    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with immediate-assertion checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  t;
    logic        ife;
    logic [31:0] addr_o;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        ir_valid;
    logic        stall_o;
    logic        fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd1),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .t         (t),
        .ife       (ife),
        .addr_o    (addr_o),
        .ir_o      (ir_o),
        .pc_o      (pc_o),
        .ir_valid  (ir_valid),
        .stall_o   (stall_o),
        .imem      (imem_bus.master),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One fetch at the current PC, ack on the first REQ cycle, followed by write-back.
    task automatic fetch_wb(input logic [31:0] word, input logic jump, input logic [31:0] tgt);
        t = PH_FETCH; tick(); t = 4'b0000;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = word; tick();
        imem_bus.imem_ack = 1'b0;
        t = PH_WB; ife = jump; addr_o = tgt; tick();
        t = 4'b0000; ife = 1'b0; addr_o = '0;
    endtask

    initial begin
        rst = 1'b0; t = 4'b0000; ife = 1'b0; addr_o = '0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
        #1;
        repeat (5) tick();
        check("rst_pc",    pc_o, 32'h0);
        check("rst_ir",    ir_o, 32'h0);
        check("rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        check("rst_stall", {31'b0, stall_o}, 32'h0);
        check("rst_valid", {31'b0, ir_valid}, 32'h0);
        check("rst_addr",  imem_bus.imem_addr, 32'h0);
        check("rst_err",   {31'b0, fetch_err}, 32'h0);

        // Normal fetch, ack on the second REQ cycle.
        rst = 1'b1; t = PH_FETCH; tick();
        check("f0_req",   {31'b0, imem_bus.imem_req}, 32'h1);
        check("f0_addr",  imem_bus.imem_addr, 32'h0);
        check("f0_stall1", {31'b0, stall_o}, 32'h1);
        t = PH_FETCH; tick();            // fetch phase repeated inside REQ must not restart
        t = 4'b0000;
        check("f0_stall2", {31'b0, stall_o}, 32'h1);
        check("f0_addr_hold", imem_bus.imem_addr, 32'h0);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h8400_0004; tick();
        imem_bus.imem_ack = 1'b0;
        check("f0_stall_done", {31'b0, stall_o}, 32'h0);
        check("f0_ir",    ir_o, 32'h8400_0004);
        check("f0_valid", {31'b0, ir_valid}, 32'h1);
        check("f0_req_lo", {31'b0, imem_bus.imem_req}, 32'h0);

        // Ack and fetch phase while DONE are both ignored.
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF; t = PH_FETCH; tick();
        imem_bus.imem_ack = 1'b0; t = 4'b0000;
        check("done_ack_ir", ir_o, 32'h8400_0004);
        check("done_t0_req", {31'b0, imem_bus.imem_req}, 32'h0);

        t = PH_WB; ife = 1'b0; tick(); t = 4'b0000;
        check("wb_pc1",    pc_o, 32'h1);
        check("wb_valid0", {31'b0, ir_valid}, 32'h0);

        // Write-back phase in IDLE and a non-one-hot phase do nothing.
        t = PH_WB; tick();
        check("idle_wb_pc", pc_o, 32'h1);
        t = 4'b0011; tick(); t = 4'b0000;
        check("nonhot_req", {31'b0, imem_bus.imem_req}, 32'h0);

        // Minimum fetch: ack on first REQ cycle.
        t = PH_FETCH; tick(); t = 4'b0000;
        check("f1_addr", imem_bus.imem_addr, 32'h1);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1111_2222; tick();
        imem_bus.imem_ack = 1'b0;
        check("f1_ir", ir_o, 32'h1111_2222);
        t = PH_WB; tick(); t = 4'b0000;
        check("wb_pc2", pc_o, 32'h2);

        // Jump taken.
        fetch_wb(32'h3333_4444, 1'b1, 32'h0000_0010);
        check("jmp_pc", pc_o, 32'h10);
        t = PH_FETCH; tick(); t = 4'b0000;
        check("jmp_addr", imem_bus.imem_addr, 32'h10);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h5555_6666; tick();
        imem_bus.imem_ack = 1'b0;
        t = PH_WB; ife = 1'b1; addr_o = 32'hFFFF_FFFF; tick();
        t = 4'b0000; ife = 1'b0; addr_o = '0;
        check("jmp_top_pc", pc_o, 32'hFFFF_FFFF);

        // Spurious ack in IDLE.
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1234_5678; tick();
        imem_bus.imem_ack = 1'b0;
        check("idle_ack_ir",  ir_o, 32'h5555_6666);
        check("idle_ack_req", {31'b0, imem_bus.imem_req}, 32'h0);

        // Sequential wrap.
        t = PH_FETCH; tick(); t = 4'b0000;
        check("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFF);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h7777_8888; tick();
        imem_bus.imem_ack = 1'b0;
        t = PH_WB; tick(); t = 4'b0000;
        check("wrap_pc", pc_o, 32'h0);

        // Jump target equal to sequential next PC.
        fetch_wb(32'h9999_AAAA, 1'b1, 32'h0000_0001);
        check("jmp_eq_pc", pc_o, 32'h1);

        // Reset mid-fetch, then a late ack.
        t = PH_FETCH; tick(); t = 4'b0000;
        check("mid_req", {31'b0, imem_bus.imem_req}, 32'h1);
        rst = 1'b0; tick();
        check("mid_rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        check("mid_rst_stall", {31'b0, stall_o}, 32'h0);
        check("mid_rst_pc",    pc_o, 32'h0);
        rst = 1'b1; tick();
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hCAFE_F00D; tick();
        imem_bus.imem_ack = 1'b0;
        check("late_ack_ir",    ir_o, 32'h0);
        check("late_ack_valid", {31'b0, ir_valid}, 32'h0);
        check("late_ack_req",   {31'b0, imem_bus.imem_req}, 32'h0);

        // Fetch with no ack.
        t = PH_FETCH; tick(); t = 4'b0000;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        check("tmo_stall15", {31'b0, stall_o}, 32'h1);
        tick();
        check("tmo_stall",  {31'b0, stall_o}, 32'h0);
        check("tmo_ir",     ir_o, 32'h0);
        check("tmo_valid",  {31'b0, ir_valid}, 32'h1);
        check("tmo_err",    {31'b0, fetch_err}, 32'h1);
        check("tmo_req",    {31'b0, imem_bus.imem_req}, 32'h0);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0; tick();
        imem_bus.imem_ack = 1'b0;
        check("tmo_late_ir", ir_o, 32'h0);
        t = PH_WB; tick(); t = 4'b0000;
        check("tmo_err_sticky", {31'b0, fetch_err}, 32'h1);
`else
        repeat (20) tick();
        check("wait_stall", {31'b0, stall_o}, 32'h1);
        check("wait_req",   {31'b0, imem_bus.imem_req}, 32'h1);
        check("wait_err",   {31'b0, fetch_err}, 32'h0);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hABCD_0123; tick();
        imem_bus.imem_ack = 1'b0;
        check("wait_ir",    ir_o, 32'hABCD_0123);
        check("wait_valid", {31'b0, ir_valid}, 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch responder for the multicycle CPU.
- Supplies ir/pc to the alu and consumes its ife/addr_o outputs to form the next PC.
- Driven by the one-hot phase vector t[3:0] from the clock/phase generator.
- Fetches from instruction memory over a req/ack handshake and raises stall_o so the phase generator freezes until the instruction arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 1, sequential PC increment (word addressed).
- TIMEOUT, 16, cycles allowed for imem_ack (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- t  in  4  one-hot phase (4'b0001 fetch, 4'b0010, 4'b0100, 4'b1000 write-back).
- ife  in  1  from alu: 1 = next PC is addr_o (jump/branch taken).
- addr_o  in  32  from alu: jump/branch target.
- ir_o  out  32  current instruction to alu.
- pc_o  out  32  PC of current instruction to alu.
- ir_valid  out  1  ir_o holds a completed fetch for pc_o.
- stall_o  out  1  fetch outstanding; phase generator must hold t.
- imem_req  out  1  fetch request, level, held until ack.
- imem_addr  out  32  fetch address (= pc_o while imem_req).
- imem_rdata  in  32  instruction word, valid with imem_ack.
- imem_ack  in  1  one-cycle completion pulse.
- fetch_err  out  1  timeout flag (FETCH_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (rst==0 sampled at a clk edge):
  - pc_o=RESET_PC, ir_o=0, ir_valid=0, imem_req=0, imem_addr=0, stall_o=0, fetch_err=0.
  - State returns to IDLE.
  - A fetch in progress is abandoned. Any imem_ack arriving after reset is ignored unless a new request is outstanding.
- FSM states:
  - IDLE: waits for t==4'b0001. On that edge: go to REQ, set imem_req=1, imem_addr=pc_o, ir_valid=0.
  - REQ: imem_req held, stall_o=1 (combinational from state). When imem_ack is sampled: ir_o<=imem_rdata, ir_valid<=1, imem_req<=0, go to DONE.
  - DONE: stall_o=0. Waits for t==4'b1000. On that edge: pc_o<=ife ? addr_o : pc_o+PC_STEP (mod 2^32), ir_valid<=0, go to IDLE.
- Latency:
  - imem_req rises 1 cycle after the t[0] edge.
  - ir_o is valid 1 cycle after the ack edge.
  - Minimum fetch is 2 cycles (ack on the first req cycle).
- Boundary conditions:
  - imem_ack in IDLE or DONE is ignored.
  - t[0] seen while in REQ/DONE is ignored (no re-fetch).
  - t[3] seen outside DONE does not update pc_o.
  - PC wraps: 32'hFFFF_FFFF+1 = 32'h0000_0000.
  - If ife=1 and addr_o equals pc_o+PC_STEP, the result is the same value (no special case).
  - A non-one-hot t is treated as no phase.
- imem_addr is stable for the whole of REQ.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter runs in REQ.
  - If TIMEOUT cycles elapse with no ack: ir_o<=32'h0000_0000 (NOP), ir_valid<=1, fetch_err<=1 (sticky until reset), imem_req<=0, go to DONE.
  - A late ack is ignored.
- FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; fetch_err tied 0.

Decomposition:
- Shared cpu_pkg holds:
  - phase constants PH_FETCH=4'b0001 and PH_WB=4'b1000;
  - NOP_INSN=32'h0000_0000;
  - the fetch FSM state enum.
- Optional sub-module pc_next: combinational next-PC select/increment (ife, addr_o, pc, PC_STEP). All other logic is in fetch_unit.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> pc_o=0, ir_o=0, imem_req=0, stall_o=0. Release and pulse t=0001 -> imem_req=1, imem_addr=0 on the next cycle.
- Normal fetch: ack 2 cycles after req with rdata=32'h8400_0004 -> stall_o high exactly 2 cycles, then ir_o=32'h8400_0004 and ir_valid=1. Then t=1000 with ife=0 -> pc_o=1.
- Jump: pc_o=2, fetch done, t=1000 with ife=1 and addr_o=32'h0000_0010 -> pc_o=32'h10. The next fetch drives imem_addr=32'h10.
- Wrap and spurious ack: RESET_PC=32'hFFFF_FFFF. Pulse imem_ack while IDLE -> ir_o unchanged. Complete a fetch, then t=1000 with ife=0 -> pc_o=0.
- Reset mid-fetch: assert rst=0 while in REQ, then release and ack 1 cycle later -> ir_o stays 0, ir_valid=0, imem_req=0.
- FETCH_TIMEOUT_EN, TIMEOUT=16, no ack -> after 16 REQ cycles ir_o=0, ir_valid=1, fetch_err=1, stall_o=0. An ack arriving afterwards is ignored.
